truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Sequential test controller for the lab's combinational gate blocks (NAND, 3/4-input AND, 4-input OR, multi-part functions). It drives every input combination of a device-under-test (DUT), waits a programmable settle time, and samples the DUT output. It compares each sample against an expected truth table and reports pass/fail, mismatch count and first failing vector. It sits beside the DUT on the board/sim top and replaces hand-written stimulus sequences with one reusable sweep engine.

## Interface
- `N_IN`, default 4: number of DUT inputs, legal range 1..6.
- `SETTLE`, default 2: extra hold cycles per vector before sampling, legal range 0..255.

- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: reset. Asynchronous assert, active-low.
- `start` input 1: begin a sweep. Sampled only in IDLE.
- `expected` input 2^N_IN: expected DUT output. Bit k is the expected value for input vector value k.
- `dut_out` input 1: DUT output under test.
- `dut_in` output N_IN: vector driven to the DUT.
- `busy` output 1: high while sweeping.
- `done` output 1: one-cycle pulse at sweep end.
- `pass` output 1: high when the last completed sweep had zero mismatches.
- `fail_count` output N_IN+1: mismatch count of the last sweep.
- `first_fail_valid` output 1: at least one mismatch occurred.
- `first_fail_idx` output N_IN: input vector value of the first mismatch, in sweep order.

## Operation
- States are IDLE, RUN and DONE.
- **IDLE**
  - `dut_in`=0 and `busy`=0.
  - `start`=1 at an edge causes the following in one step:
    - `expected` is captured into an internal register.
    - Vector counter is set to step 0 and settle counter to `SETTLE`.
    - `pass`, `fail_count`, `first_fail_valid` and `first_fail_idx` are cleared.
    - `busy` goes to 1.
    - State moves to RUN.
- **RUN**
  - `dut_in` = vector for the current step.
  - Each edge with settle counter >0 decrements it.
  - On the edge with settle counter ==0:
    - `dut_out` is compared with the captured expected bit at index `dut_in`.
    - On mismatch, `fail_count` increments.
    - On the first mismatch, `first_fail_idx` is loaded with `dut_in` and `first_fail_valid` is set to 1.
    - If the step is the last (2^N_IN−1), state moves to DONE. Otherwise the step increments and the settle counter reloads.
- **DONE**
  - Lasts exactly one cycle: `done`=1, `busy`=0, `dut_in`=0.
  - `pass` = (`fail_count`==0), registered on entry.
  - Then the state returns to IDLE.
- Result outputs hold their values until the next accepted `start`.
- `start` in RUN or DONE is ignored and not queued.
- Changes to `expected` after capture are ignored.
- `fail_count` cannot overflow: its maximum is 2^N_IN, which fits in N_IN+1 bits.
- `dut_out` is compared with `!==` semantics in simulation, so an X counts as a mismatch.

## Timing
- Reset value of every output is 0; state resets to IDLE.
- `rst_n` low mid-sweep aborts immediately and asynchronously and clears all results.
- Each vector is held for exactly `SETTLE`+1 cycles.
- Sample point is the last edge of that hold.
- `done` is high in the cycle after edge E0 + 2^N_IN·(SETTLE+1), where E0 is the edge that accepted `start`.
- Defaults give `done` 48 cycles after E0.
- `busy` rises after E0 and falls when `done` rises.
- Back-to-back sweeps: the earliest new `start` is accepted on the edge ending the `done` cycle (IDLE entry) + 1 cycle.

## Configuration
- Macro `SWEEP_GRAY_EN`.
- Defined: step k drives `dut_in` = k ^ (k>>1). Gray order means exactly one DUT input toggles per step, which suppresses hazard glitches.
- Undefined: step k drives `dut_in` = k (binary order).
- In both modes `expected` is indexed by the `dut_in` value, not by step number. Only `first_fail_idx` ordering effects differ.

## Structure
- Package `sweep_pkg` holds:
  - State enum (IDLE, RUN, DONE).
  - Default parameter constants.
  - Localparam width helpers: vector count and count width.
- One sub-module, `sweep_step_enc`, is combinational. It maps step to `dut_in` (binary or Gray per `SWEEP_GRAY_EN`).

## Test plan
Default parameters unless stated.
- **AND4 pass:** DUT = AND of `dut_in`, `expected`=16'h8000, pulse `start` → `done` 48 cycles after E0, `pass`=1, `fail_count`=0, `first_fail_valid`=0.
- **Wrong table:** DUT = AND4, `expected`=16'h7FFF (NAND4) → `fail_count`=16, `first_fail_idx`=0, `pass`=0.
- **Stuck-at-0:** DUT `dut_out`=0, `expected`=16'hFFFE (OR4) → `fail_count`=15, `first_fail_idx`=1 in both orderings.
- **Ignored inputs:** during RUN, pulse `start` and change `expected` to 16'h0000 → result identical to the AND4 pass case, and `done` timing unchanged.
- **Abort:** drop `rst_n` 20 cycles after E0 → all outputs 0 before the next edge. Restart after reset completes normally.
- **Step order and corner parameters:**
  - With `SWEEP_GRAY_EN` defined, `dut_in` sequence is 0,1,3,2,6,7,5,4,… with Hamming distance 1 per step.
  - With `SWEEP_GRAY_EN` undefined, the sequence is 0,1,2,3,…
  - With N_IN=2, SETTLE=0: `done` 4 cycles after E0.

Source files
------------

// File: rtl/sweep_pkg.sv
//==============================================================================
// sweep_pkg : shared types and sizing helpers for the truth-table sweeper
// Rev 1.0
//==============================================================================
`default_nettype none

package sweep_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_N_IN   = 4;
   localparam int DEF_SETTLE = 2;

   // Number of input vectors for an n-input DUT
   function automatic int vec_count(input int n);
      return 1 << n;
   endfunction

   // Mismatch counter must hold 2^n, hence one extra bit
   function automatic int cnt_width(input int n);
      return n + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sweep_step_enc.sv
//==============================================================================
// sweep_step_enc : maps sweep step number to the vector driven on the DUT
// Gray order when SWEEP_GRAY_EN is defined, binary order otherwise. Rev 1.0
//==============================================================================
`default_nettype none

module sweep_step_enc #(
   parameter int N = 4
) (
   input  logic [N-1:0] i_step,
   output logic [N-1:0] o_vec
);

`ifdef SWEEP_GRAY_EN
   // Exactly one DUT input toggles between consecutive steps
   assign o_vec = i_step ^ (i_step >> 1);
`else
   assign o_vec = i_step;
`endif

endmodule

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
//==============================================================================
// truth_table_sweeper : drives every input vector of a combinational DUT and
// checks its output against a captured truth table (order: SWEEP_GRAY_EN). Rev 1.0
//==============================================================================
`default_nettype none

module truth_table_sweeper
   import sweep_pkg::*;
#(
   parameter int N_IN   = DEF_N_IN,
   parameter int SETTLE = DEF_SETTLE
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic [vec_count(N_IN)-1:0]        expected,
   input  logic                              dut_out,
   output logic [N_IN-1:0]                   dut_in,
   output logic                              busy,
   output logic                              done,
   output logic                              pass,
   output logic [cnt_width(N_IN)-1:0]        fail_count,
   output logic                              first_fail_valid,
   output logic [N_IN-1:0]                   first_fail_idx
);

   localparam int              VEC_N    = vec_count(N_IN);
   localparam int              CNT_W    = cnt_width(N_IN);
   localparam logic [N_IN-1:0] c_LAST   = '1;
   localparam logic [7:0]      c_SETTLE = 8'(SETTLE);

   state_t             r_state;
   state_t             w_next;
   logic [VEC_N-1:0]   r_exp;
   logic [N_IN-1:0]    r_step;
   logic [7:0]         r_settle;
   logic [N_IN-1:0]    w_vec;
   logic               w_accept;
   logic               w_sample;
   logic               w_last;
   logic               w_mismatch;
   logic [CNT_W-1:0]   w_fc_next;

   sweep_step_enc #(
      .N (N_IN)
   ) u_enc (
      .i_step (r_step),
      .o_vec  (w_vec)
   );

   assign w_accept   = (r_state == IDLE) && start;
   assign w_sample   = (r_state == RUN) && (r_settle == 8'd0);
   assign w_last     = (r_step == c_LAST);
   // Case inequality so an undriven / X DUT output is reported as a mismatch
   assign w_mismatch = (dut_out !== r_exp[w_vec]);
   assign w_fc_next  = fail_count + {{N_IN{1'b0}}, w_mismatch};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      dut_in = '0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next = RUN;
            end
         end
         RUN: begin
            busy   = 1'b1;
            dut_in = w_vec;
            if (w_sample && w_last) begin
               w_next = DONE;
            end
         end
         DONE: begin
            done   = 1'b1;
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_exp            <= '0;
         r_step           <= '0;
         r_settle         <= 8'd0;
         pass             <= 1'b0;
         fail_count       <= '0;
         first_fail_valid <= 1'b0;
         first_fail_idx   <= '0;
      end else if (w_accept) begin
         r_exp            <= expected;
         r_step           <= '0;
         r_settle         <= c_SETTLE;
         pass             <= 1'b0;
         fail_count       <= '0;
         first_fail_valid <= 1'b0;
         first_fail_idx   <= '0;
      end else if (r_state == RUN) begin
         if (!w_sample) begin
            r_settle <= r_settle - 8'd1;
         end else begin
            fail_count <= w_fc_next;
            if (w_mismatch && !first_fail_valid) begin
               first_fail_valid <= 1'b1;
               first_fail_idx   <= w_vec;
            end
            if (w_last) begin
               // Includes the final sample, so pass is valid on DONE entry
               pass <= (w_fc_next == '0);
            end else begin
               r_step   <= r_step + 1'b1;
               r_settle <= c_SETTLE;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
//==============================================================================
// tb_truth_table_sweeper : directed, scoreboard-based bench for truth_table_sweeper
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_truth_table_sweeper;

   localparam int N_IN   = 4;
   localparam int SETTLE = 2;
   localparam int VEC_N  = 1 << N_IN;
   localparam int HOLD   = SETTLE + 1;
   localparam int SWEEP  = VEC_N * HOLD;

   typedef struct packed {
      logic            pass;
      logic [N_IN:0]   fc;
      logic            ffv;
      logic [N_IN-1:0] ffi;
   } res_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [VEC_N-1:0]  expected = '0;
   logic              dut_out;
   logic [N_IN-1:0]   dut_in;
   logic              busy;
   logic              done;
   logic              pass;
   logic [N_IN:0]     fail_count;
   logic              first_fail_valid;
   logic [N_IN-1:0]   first_fail_idx;

   int   checks   = 0;
   int   failures = 0;
   int   dut_kind = 0;
   res_t sb_q[$];

   always #5 clk = ~clk;

   // 0: 4-input AND gate, 1: output stuck at 0
   always_comb dut_out = (dut_kind == 0) ? (&dut_in) : 1'b0;

   truth_table_sweeper #(
      .N_IN   (N_IN),
      .SETTLE (SETTLE)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .expected         (expected),
      .dut_out          (dut_out),
      .dut_in           (dut_in),
      .busy             (busy),
      .done             (done),
      .pass             (pass),
      .fail_count       (fail_count),
      .first_fail_valid (first_fail_valid),
      .first_fail_idx   (first_fail_idx)
   );

   function automatic logic [N_IN-1:0] step_vec(input int k);
`ifdef SWEEP_GRAY_EN
      return N_IN'(k ^ (k >> 1));
`else
      return N_IN'(k);
`endif
   endfunction

   function automatic res_t model(input logic [VEC_N-1:0] tbl, input int kind);
      res_t            r;
      logic [N_IN-1:0] v;
      logic            o;
      r = '0;
      for (int k = 0; k < VEC_N; k++) begin
         v = step_vec(k);
         o = (kind == 0) ? (&v) : 1'b0;
         if (o !== tbl[v]) begin
            r.fc = r.fc + 1'b1;
            if (!r.ffv) begin
               r.ffv = 1'b1;
               r.ffi = v;
            end
         end
      end
      r.pass = (r.fc == '0);
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_results(input string tag, input res_t r);
      check({tag, "_pass"}, 32'(pass), 32'(r.pass));
      check({tag, "_fail_count"}, 32'(fail_count), 32'(r.fc));
      check({tag, "_ffv"}, 32'(first_fail_valid), 32'(r.ffv));
      check({tag, "_ffi"}, 32'(first_fail_idx), 32'(r.ffi));
   endtask

   // Starts a sweep, follows it cycle by cycle and checks the result on done
   task automatic run_sweep(input string tag, input logic [VEC_N-1:0] tbl,
                            input int kind, input bit ignore);
      res_t r;
      r = '0;
      dut_kind = kind;
      @(negedge clk);
      start    = 1'b1;
      expected = tbl;
      sb_q.push_back(model(tbl, kind));
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c <= SWEEP + 1; c++) begin
         if (c > 0) @(negedge clk);
         if (c < SWEEP) begin
            if ((c % HOLD) == 0) begin
               check({tag, "_dut_in"}, 32'(dut_in), 32'(step_vec(c / HOLD)));
            end
            check({tag, "_busy_done_run"}, 32'({busy, done}), 32'(2'b10));
            if (ignore && c == 10) begin
               start    = 1'b1;
               expected = '0;
            end
            if (ignore && c == 11) start = 1'b0;
         end else if (c == SWEEP) begin
            check({tag, "_done_cycle"}, 32'({busy, done, dut_in}),
                  32'({1'b0, 1'b1, {N_IN{1'b0}}}));
            check({tag, "_sb_size"}, 32'(sb_q.size()), 32'd1);
            if (sb_q.size() > 0) r = sb_q.pop_front();
            check_results(tag, r);
            if (ignore) start = 1'b1;
         end else begin
            start = 1'b0;
            check({tag, "_after_done"}, 32'({busy, done}), 32'(2'b00));
            check({tag, "_hold_fc"}, 32'(fail_count), 32'(r.fc));
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("reset_outputs",
            32'({dut_in, busy, done, pass, fail_count, first_fail_valid, first_fail_idx}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_outputs", 32'({dut_in, busy, done}), 32'd0);

      run_sweep("and4_pass",   16'h8000, 0, 1'b0);
      run_sweep("wrong_table", 16'h7FFF, 0, 1'b0);
      run_sweep("stuck0",      16'hFFFE, 1, 1'b0);
      run_sweep("ignored",     16'h8000, 0, 1'b1);
      run_sweep("fail_after_pass", 16'h8001, 0, 1'b0);

      // Abort mid-sweep: outputs must clear before the next edge
      dut_kind = 0;
      @(negedge clk);
      start    = 1'b1;
      expected = 16'h8000;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      check("abort_busy_before", 32'(busy), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("abort_outputs",
            32'({dut_in, busy, done, pass, fail_count, first_fail_valid, first_fail_idx}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_idle", 32'({dut_in, busy, done}), 32'd0);

      run_sweep("restart", 16'h8000, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
